// File: rtl/lcd_fifo_dev.sv
// Write FIFO feeding an HD44780-style LCD bus: each queued byte is replayed with setup/enable/hold/wait timing.
// Optional sticky overflow status is compiled in by defining LCD_FIFO_DEV_OVF_STICKY_EN.
module lcd_fifo_dev #(
    parameter int DEPTH     = 16,
    parameter int SETUP_CYC = 2,
    parameter int E_CYC     = 12,
    parameter int HOLD_CYC  = 2,
    parameter int WAIT_CYC  = 2000,
    parameter int LONG_CYC  = 82000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] d,
    input  logic        w7,
    output logic [31:0] q,
    output logic [7:0]  lcd_db,
    output logic        lcd_e,
    output logic        lcd_rs,
    output logic        lcd_rw
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = AW + 1;
    localparam int MAX_A = (SETUP_CYC > E_CYC) ? SETUP_CYC : E_CYC;
    localparam int MAX_B = (HOLD_CYC > WAIT_CYC) ? HOLD_CYC : WAIT_CYC;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_CYC = (MAX_C > LONG_CYC) ? MAX_C : LONG_CYC;
    localparam int TW    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    // Timer reload values: a phase of N cycles counts N-1 down to 0.
    localparam logic [TW-1:0] SETUP_LD = TW'(SETUP_CYC - 1);
    localparam logic [TW-1:0] E_LD     = TW'(E_CYC - 1);
    localparam logic [TW-1:0] HOLD_LD  = TW'(HOLD_CYC - 1);
    localparam logic [TW-1:0] WAIT_LD  = TW'(WAIT_CYC - 1);
    localparam logic [TW-1:0] LONG_LD  = TW'(LONG_CYC - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT
    } state_t;

    // FIFO storage and bookkeeping
    logic [8:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Transfer engine
    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          rs_q, rs_d;
    logic [7:0]    db_q, db_d;
    logic          e_q, e_d;
    logic [31:0]   q_q, q_d;

    logic          pop;
    logic          wr_en;
    logic          flush;
    logic          accept;
    logic          drop;
    logic          long_cmd;
    logic          ovf;
    logic [8:0]    count9;
    logic [7:0]    count_sat;

    assign pop      = (state_q == S_IDLE) && (count_q != '0);
    assign wr_en    = w7 && !d[9];
    assign flush    = w7 && d[9];
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign accept   = wr_en && ((count_q != DEPTH_C) || pop);
    assign drop     = wr_en && !accept;
    assign long_cmd = !rs_q && ((db_q == 8'h01) || (db_q == 8'h02));

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(accept) - CW'(pop);
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end
    end

    // NOTE: the storage array has no reset; validity is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= d[8:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef LCD_FIFO_DEV_OVF_STICKY_EN
    logic ovf_q, ovf_d;

    // A word dropped in the same cycle as a clear still leaves the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (w7 && d[10]) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;

    logic unused_bits;
    assign unused_bits = ^d[31:11];
`else
    assign ovf = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{d[31:10], drop};
`endif

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        rs_d    = rs_q;
        db_d    = db_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d      = S_SETUP;
                    tmr_d        = SETUP_LD;
                    {rs_d, db_d} = mem_q[rd_ptr_q];
                end
            end
            S_SETUP: begin
                if (tmr_q == '0) begin
                    state_d = S_PULSE;
                    tmr_d   = E_LD;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_PULSE: begin
                if (tmr_q == '0) begin
                    state_d = S_HOLD;
                    tmr_d   = HOLD_LD;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_HOLD: begin
                if (tmr_q == '0) begin
                    state_d = S_WAIT;
                    tmr_d   = long_cmd ? LONG_LD : WAIT_LD;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_WAIT: begin
                if (tmr_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                tmr_d   = '0;
            end
        endcase
    end

    // Enable is registered from the next state so it is glitch-free and aligned with PULSE.
    assign e_d = (state_d == S_PULSE);

    assign count9    = 9'(count_q);
    assign count_sat = count9[8] ? 8'hFF : count9[7:0];

    always_comb begin
        q_d        = '0;
        q_d[0]     = (count_q == '0);
        q_d[1]     = (count_q == DEPTH_C);
        q_d[2]     = (state_q != S_IDLE);
        q_d[3]     = ovf;
        q_d[15:8]  = count_sat;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            rs_q    <= 1'b0;
            db_q    <= 8'h00;
            e_q     <= 1'b0;
            q_q     <= 32'h0000_0001;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            rs_q    <= rs_d;
            db_q    <= db_d;
            e_q     <= e_d;
            q_q     <= q_d;
        end
    end

    assign q      = q_q;
    assign lcd_db = db_q;
    assign lcd_rs = rs_q;
    assign lcd_e  = e_q;
    assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_fifo_dev.sv
// Scoreboard bench for lcd_fifo_dev: stimulus queues expected LCD transfers, a monitor checks each enable pulse.
// Runs with shortened WAIT/LONG delays so the long-command case stays quick.
module tb_lcd_fifo_dev;

    localparam int DEPTH    = 16;
    localparam int SETUP    = 2;
    localparam int ECYC     = 12;
    localparam int HOLD     = 2;
    localparam int WAITC    = 40;
    localparam int LONGC    = 300;
    localparam int XFER     = SETUP + ECYC + HOLD + WAITC;
    localparam int NORM_GAP = ECYC + HOLD + WAITC + 1 + SETUP;
    localparam int LONG_GAP = ECYC + HOLD + LONGC + 1 + SETUP;
`ifdef LCD_FIFO_DEV_OVF_STICKY_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        w7;
    logic [31:0] d;
    logic [31:0] q;
    logic [7:0]  lcd_db;
    logic        lcd_e;
    logic        lcd_rs;
    logic        lcd_rw;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic       rs;
        logic [7:0] db;
        int         gap;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   rise_cnt  = 0;
    int   last_rise = 0;
    int   hi_cnt    = 0;
    logic in_pulse  = 1'b0;

    lcd_fifo_dev #(
        .DEPTH    (DEPTH),
        .SETUP_CYC(SETUP),
        .E_CYC    (ECYC),
        .HOLD_CYC (HOLD),
        .WAIT_CYC (WAITC),
        .LONG_CYC (LONGC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .d     (d),
        .w7    (w7),
        .q     (q),
        .lcd_db(lcd_db),
        .lcd_e (lcd_e),
        .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] word);
        @(negedge clk);
        d  = word;
        w7 = 1'b1;
    endtask

    task automatic wr_end();
        @(negedge clk);
        w7 = 1'b0;
        d  = '0;
    endtask

    task automatic expect_xfer(input logic [8:0] v, input int gap);
        exp_t e;
        e.rs  = v[8];
        e.db  = v[7:0];
        e.gap = gap;
        sb.push_back(e);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        cycles(3);
        while (q !== 32'h1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, q, 32'h1);
    endtask

    // Monitor: every rising lcd_e pops one expected transfer; every full pulse must be ECYC wide.
    always @(negedge clk) begin
        if (reset) begin
            in_pulse = 1'b0;
            hi_cnt   = 0;
        end else if (lcd_e && !in_pulse) begin
            in_pulse = 1'b1;
            hi_cnt   = 1;
            if (sb.size() == 0) begin
                check("unexpected_pulse", {23'h0, lcd_rs, lcd_db}, 32'hFFFF_FFFF);
            end else begin
                mon_e = sb.pop_front();
                check("xfer_rs", 32'(lcd_rs), 32'(mon_e.rs));
                check("xfer_db", 32'(lcd_db), 32'(mon_e.db));
                check("xfer_rw", 32'(lcd_rw), 32'h0);
                if (mon_e.gap >= 0) begin
                    check("xfer_gap", 32'(cyc - last_rise), 32'(mon_e.gap));
                end
            end
            last_rise = cyc;
            rise_cnt++;
        end else if (lcd_e) begin
            hi_cnt++;
        end else if (in_pulse) begin
            in_pulse = 1'b0;
            check("e_width", 32'(hi_cnt), 32'(ECYC));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   w_edge;
        int   saved;

        reset = 1'b1;
        w7    = 1'b0;
        d     = '0;
        cycles(3);
        check("rst_q", q, 32'h1);
        check("rst_e", 32'(lcd_e), 32'h0);
        check("rst_db", 32'(lcd_db), 32'h0);
        check("rst_rs", 32'(lcd_rs), 32'h0);
        check("rst_rw", 32'(lcd_rw), 32'h0);
        reset = 1'b0;
        cycles(2);

        // Single data byte from idle: bus shows it two cycles after w7, busy lasts one full transfer.
        expect_xfer(9'h141, -1);
        wr(32'h141);
        wr_end();
        check("db_lag1", 32'(lcd_db), 32'h0);
        @(negedge clk);
        check("db_lag2", 32'(lcd_db), 32'h41);
        check("rs_lag2", 32'(lcd_rs), 32'h1);
        n = 0;
        while (!q[2] && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (q[2] && n < 5000) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles", 32'(n), 32'(XFER));
        check("after_a_q", q, 32'h1);

        // Clear/home commands get the long wait; rs=1 with 0x01 does not.
        expect_xfer(9'h001, -1);
        expect_xfer(9'h142, LONG_GAP);
        expect_xfer(9'h002, NORM_GAP);
        expect_xfer(9'h101, LONG_GAP);
        expect_xfer(9'h146, NORM_GAP);
        wr(32'h001);
        wr(32'h142);
        wr(32'h002);
        wr(32'h101);
        wr(32'h146);
        wr_end();
        wait_idle("cmd_seq_idle", 3000);

        // Fill while busy: 16 of 17 accepted, then clear overflow.
        expect_xfer(9'h150, -1);
        expect_xfer(9'h151, NORM_GAP);
        wr(32'h150);
        w_edge = cyc + 1;
        for (int i = 1; i <= 17; i++) begin
            wr(32'h150 + 32'(i));
        end
        wr_end();
        cycles(1);
        check("full_q", q, {16'h0, 8'd16, 4'h0, OVF_EXP, 1'b1, 1'b1, 1'b0});
        wr(32'h400);
        wr_end();
        cycles(1);
        check("ovf_clr_q", q, 32'h0000_1006);

        // Write landing in the IDLE->SETUP pop cycle of a full FIFO.
        while (cyc < w_edge + XFER) @(negedge clk);
        wr(32'h170);
        wr_end();
        cycles(1);
        check("pop_cycle_wr_q", q, 32'h0000_1006);

        // Flush mid-pulse: queue empties, current pulse runs to full width.
        cycles(3);
        wr(32'h200);
        wr_end();
        cycles(1);
        check("flush_q", q, 32'h0000_0005);
        check("flush_e_kept", 32'(lcd_e), 32'h1);
        wait_idle("flush_idle", 500);
        cycles(20);
        check("sb_drained", 32'(sb.size()), 32'h0);

        // Reset in the middle of a pulse with five entries behind it.
        expect_xfer(9'h181, -1);
        for (int i = 0; i < 6; i++) begin
            wr(32'h181 + 32'(i));
        end
        wr_end();
        n = 0;
        while (!lcd_e && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("pulse_seen", 32'(lcd_e), 32'h1);
        cycles(3);
        saved = rise_cnt;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_mid_e", 32'(lcd_e), 32'h0);
        @(posedge clk);
        #1;
        check("rst_mid_q", q, 32'h1);
        cycles(2);
        reset = 1'b0;
        cycles(100);
        check("no_pulse_after_rst", 32'(rise_cnt), 32'(saved));
        check("final_q", q, 32'h1);
        check("final_db", 32'(lcd_db), 32'h0);
        check("sb_empty_end", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lcd_fifo_dev.md
LCD_FIFO_DEV -- requirements
Module: lcd_fifo_dev

Interface
REQ-001 SHALL have parameter DEPTH, 16, FIFO entries (power of two, 2..256).
REQ-002 SHALL have parameter SETUP_CYC, 2, cycles rs/db stable before lcd_e rises.
REQ-003 SHALL have parameter E_CYC, 12, cycles lcd_e held high.
REQ-004 SHALL have parameter HOLD_CYC, 2, cycles rs/db held after lcd_e falls.
REQ-005 SHALL have parameter WAIT_CYC, 2000, post-transfer delay for normal bytes.
REQ-006 SHALL have parameter LONG_CYC, 82000, post-transfer delay for commands 0x01/0x02.
REQ-007 SHALL have port clk  input  1  single clock, rising edge.
REQ-008 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port d  input  32  write word: [7:0] byte, [8] rs, [9] flush, [10] clear overflow.
REQ-010 SHALL have port w7  input  1  write strobe, one word per asserted cycle.
REQ-011 SHALL have port q  output  32  status: [0] empty, [1] full, [2] busy, [3] overflow, [15:8] count, others 0.
REQ-012 SHALL have port lcd_db  output  8  LCD data bus.
REQ-013 SHALL have ports lcd_e, lcd_rs, lcd_rw  output  1 each  enable, register select, read/write.

Function
REQ-014 Write with d[9]=0 SHALL enqueue {d[8],d[7:0]}; d[9]=1 SHALL empty the FIFO and enqueue nothing.
REQ-015 Write with d[10]=1 SHALL clear overflow; combinable with enqueue or flush in the same word.
REQ-016 Enqueue SHALL be accepted when count<DEPTH, or when count==DEPTH and a pop occurs that cycle.
REQ-017 Otherwise the word SHALL be dropped, FIFO unchanged, overflow set.
REQ-018 FIFO pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH and saturate into q[15:8].
REQ-019 FSM states: IDLE, SETUP, PULSE, HOLD, WAIT.
REQ-020 IDLE -> SETUP when FIFO non-empty; head entry popped and latched into lcd_rs/lcd_db that edge.
REQ-021 SETUP lasts SETUP_CYC, PULSE E_CYC (lcd_e=1 only here), HOLD HOLD_CYC, then -> WAIT.
REQ-022 WAIT SHALL last LONG_CYC if latched rs=0 and byte is 0x01 or 0x02, else WAIT_CYC; then -> IDLE.
REQ-023 Flush during a transfer SHALL NOT abort it; the in-flight byte completes with full timing.
REQ-024 Write arriving while count==0 and FSM IDLE SHALL appear on lcd_db 2 cycles after the w7 edge.
REQ-025 lcd_rw SHALL be constant 0; lcd_db/lcd_rs SHALL hold last latched value outside transfers.
REQ-026 q SHALL be registered, reflecting state of the previous cycle (1-cycle lag).
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 Delay counters SHALL be sized by $clog2 of the largest timing parameter; no truncation.

Reset
REQ-029 reset SHALL act asynchronously: FSM IDLE, FIFO empty, pointers 0, overflow 0.
REQ-030 During/after reset: lcd_e=0, lcd_rs=0, lcd_db=0x00, lcd_rw=0, q=0x00000001.
REQ-031 reset mid-PULSE SHALL drop lcd_e immediately, without waiting for clk.

Configuration
REQ-032 Macro LCD_FIFO_DEV_OVF_STICKY_EN defined: overflow sticky until a d[10]=1 write or reset.
REQ-033 Macro undefined: overflow logic omitted, q[3] constant 0, dropped writes silently discarded, d[10] ignored.

Verification
REQ-034 Reset, write 0x141 (data 'A'): lcd_db=0x41, lcd_rs=1; lcd_e high exactly 12 cycles, busy cleared 2016 cycles after pop.
REQ-035 Write 0x001 (clear cmd): WAIT lasts 82000 cycles; next queued byte's lcd_e rises no earlier.
REQ-036 17 writes back-to-back with FSM busy: 16 accepted, count=16, full=1, overflow=1 (macro defined) / 0 (undefined).
REQ-037 Write 0x400: overflow cleared, count unchanged; write 0x200 mid-PULSE: FIFO empty, current lcd_e pulse completes.
REQ-038 Assert reset during PULSE with 5 entries queued: lcd_e=0 same cycle, q=0x00000001 next edge, no further pulses.
REQ-039 Write into full FIFO in the IDLE->SETUP pop cycle: accepted, count stays 16, overflow stays 0.
